// File: rtl/jaddr_split_if.sv
// Request/result bundle for the jump-address splitter.
// The requester side (master) drives a jump target plus delay-slot PC and
// consumes encoded J-type words; the splitter itself is the slave.
interface jaddr_split_if;
    // Request channel
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_target;
    logic [31:0] in_pc;
    logic        in_link;

    // Result channel
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [3:0]  out_region;
    logic [25:0] out_index;
    logic [1:0]  out_err;

    // Running count of requests that carried an error
    logic [15:0] err_count;

    modport master (
        output in_valid, in_target, in_pc, in_link, out_ready,
        input  in_ready, out_valid, out_instr, out_region, out_index,
               out_err, err_count
    );

    modport slave (
        input  in_valid, in_target, in_pc, in_link, out_ready,
        output in_ready, out_valid, out_instr, out_region, out_index,
               out_err, err_count
    );
endinterface

// File: rtl/jaddr_split.sv
// Jump-address splitter.
// Takes a jump target and the delay-slot PC, checks alignment and 256 MB
// region reachability, and queues the encoded J/JAL word together with the
// raw region/index fields in a 2-entry FIFO. Error entries carry a zero
// instruction word and bump a saturating error counter.
module jaddr_split #(
    parameter logic [5:0] OP_J   = 6'b000010,
    parameter logic [5:0] OP_JAL = 6'b000011
) (
    input logic          clk,
    input logic          rst,
    jaddr_split_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  region;
        logic [25:0] index;
        logic [1:0]  err;
    } entry_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        pop;
    logic        wr_ptr;
    logic        rd_ptr;
    entry_t      new_entry;
    entry_t      head;
    entry_t      mem [2];
    logic [15:0] err_count_q;

    // Only the region nibble of the PC matters; the rest is deliberately ignored.
    logic        unused_pc;
    assign unused_pc = ^bus.in_pc[27:0];

    // Handshake qualifiers: FULL never accepts, even with a pop in the same cycle.
    always_comb begin
        bus.in_ready  = (state != FULL);
        bus.out_valid = (state != EMPTY);
        accept        = bus.in_valid && bus.in_ready;
        pop           = bus.out_valid && bus.out_ready;
    end

    // Encode the incoming request; error flags are fixed at accept time.
    always_comb begin
        new_entry        = '0;
        new_entry.region = bus.in_target[31:28];
        new_entry.index  = bus.in_target[27:2];
        new_entry.err[0] = (bus.in_target[1:0] != 2'b00);
        new_entry.err[1] = (bus.in_target[31:28] != bus.in_pc[31:28]);
        if (new_entry.err == 2'b00) begin
            new_entry.instr = {(bus.in_link ? OP_JAL : OP_J), bus.in_target[27:2]};
        end
    end

    // Occupancy state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the 2-entry occupancy FSM.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !pop)      state_nxt = FULL;
                else if (pop && !accept) state_nxt = EMPTY;
            end
            FULL:  if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Read/write pointers; reset drops any buffered entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
        end
    end

    // Entry storage.
    // NOTE: the storage array is deliberately not reset; the outputs are gated by
    // out_valid, so stale contents are never observable and resetting it
    // would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= new_entry;
    end

    // Saturating error counter over accepted requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= 16'h0000;
        end else if (accept && (new_entry.err != 2'b00) && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    // Present the head entry, forced to zero whenever the FIFO is empty.
    always_comb begin
        head           = mem[rd_ptr];
        bus.out_instr  = 32'h0000_0000;
        bus.out_region = 4'h0;
        bus.out_index  = 26'h000_0000;
        bus.out_err    = 2'b00;
        if (bus.out_valid) begin
            bus.out_instr  = head.instr;
            bus.out_region = head.region;
            bus.out_index  = head.index;
            bus.out_err    = head.err;
        end
        bus.err_count = err_count_q;
    end

endmodule

// File: doc/jaddr_split.md
JADDR_SPLIT -- requirements
Module: jaddr_split

Interface
REQ-001 Parameter: OP_J, default 6'b000010, opcode emitted for plain jump.
REQ-002 Parameter: OP_JAL, default 6'b000011, opcode emitted for jump-and-link.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_target  input  32  jump target byte address.
REQ-008 in_pc  input  32  delay-slot PC (PC+4); its bits [31:28] define the reachable region.
REQ-009 in_link  input  1  1 = JAL encoding, 0 = J encoding.
REQ-010 out_valid  output  1  result entry available.
REQ-011 out_ready  input  1  consumer takes the head entry this cycle.
REQ-012 out_instr  output  32  encoded J-type word {opcode, index}, or 0 on error.
REQ-013 out_region  output  4  in_target[31:28] of the head entry.
REQ-014 out_index  output  26  in_target[27:2] of the head entry.
REQ-015 out_err  output  2  bit0 = misaligned, bit1 = region mismatch.
REQ-016 err_count  output  16  saturating count of accepted requests with out_err != 0.

Function
REQ-017 Accept occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-018 Storage is a 2-entry FIFO. The FSM states are EMPTY, ONE and FULL; in_ready = (state != FULL) and out_valid = (state != EMPTY).
REQ-019 FSM transitions:
- EMPTY + accept -> ONE.
- ONE + accept without pop -> FULL.
- ONE + pop without accept -> EMPTY.
- ONE + accept with pop -> ONE.
- FULL + pop -> ONE.
- All other combinations hold state.
REQ-020 In FULL, in_ready is 0 even when out_ready is 1; no same-cycle push-through when full.
REQ-021 Latency: a request accepted on edge N is visible on the outputs after edge N when the FIFO was empty; otherwise it waits behind the older entry. Order is strictly FIFO.
REQ-022 Error flags are computed at accept time:
- err[0] = (in_target[1:0] != 2'b00).
- err[1] = (in_target[31:28] != in_pc[31:28]).
REQ-023 If err == 0, out_instr = {in_link ? OP_JAL : OP_J, in_target[27:2]}; if err != 0, out_instr = 32'h0000_0000.
REQ-024 out_region and out_index are always the raw fields, regardless of error.
REQ-025 err_count increments by 1 on each accept with a nonzero error and holds at 16'hFFFF.
REQ-026 When out_valid = 0, out_instr, out_region, out_index and out_err read 0.
REQ-027 Inputs are sampled only on accept; changes while in_ready = 0 have no effect.
REQ-028 Outputs are stable while out_valid && !out_ready.

Reset
REQ-029 On rst = 1, the following take effect immediately without a clock edge:
- state = EMPTY.
- in_ready = 1, out_valid = 0.
- All data outputs = 0.
- err_count = 0.
REQ-030 Reset mid-operation discards all buffered entries; the first accept after rst falls is treated as a fresh EMPTY -> ONE transition.

Verification
REQ-031 Plain J: target 0x00400020, pc 0x00400004, link 0 -> one cycle later out_valid = 1, out_instr = 0x08100008, out_region = 0x0, out_index = 0x0100008, out_err = 0.
REQ-032 JAL: same addresses with link 1 -> out_instr = 0x0C100008.
REQ-033 Misaligned: target 0x00400022, pc 0x00400004 -> out_err = 01, out_instr = 0, err_count 0 -> 1.
REQ-034 Region mismatch: target 0x10000000, pc 0x00400004 -> out_err = 10, out_instr = 0, out_region = 0x1.
REQ-035 Backpressure and ordering:
- Hold out_ready = 0 and present 3 back-to-back valid requests: the first two are accepted and in_ready falls to 0.
- Then raise out_ready: entries pop in order, and the third is accepted the cycle after the first pop.
REQ-036 Async reset in FULL: assert rst between edges -> out_valid = 0 and in_ready = 1 immediately, err_count = 0, and no stale entry appears after rst is released.
